// File: rtl/register_bank_pkg.sv
// Shared types and constants for the register bank datapath block.
// Optional REGISTER_BANK_SAT_EN selects saturating inc/dec in register_cell.
package register_bank_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    FS_DEC  = 3'b000,
    FS_INC  = 3'b001,
    FS_LOAD = 3'b010,
    FS_CLR  = 3'b011,
    FS_LDZX = 3'b100,
    FS_LDLO = 3'b101,
    FS_LDHI = 3'b110,
    FS_SHL8 = 3'b111
  } funsel_e;

  // True when a register width is a whole number of bytes and wide enough for the high-byte lane.
  function automatic bit width_ok(input int w);
    return (w % BYTE_W == 0) && (w >= 2 * BYTE_W);
  endfunction

endpackage

// File: rtl/register_cell.sv
// One bank register: FunSel decode, enable, and overflow detection on inc/dec.
// With REGISTER_BANK_SAT_EN defined, inc/dec saturate instead of wrapping.
module register_cell
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  funsel_e          fun_sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             wrap_hit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next   = q_reg;
    wrap_hit = 1'b0;
    if (en) begin
      case (fun_sel)
        FS_DEC: begin
          wrap_hit = (q_reg == '0);
`ifdef REGISTER_BANK_SAT_EN
          q_next = wrap_hit ? q_reg : q_reg - ONE;
`else
          q_next = q_reg - ONE;
`endif
        end
        FS_INC: begin
          wrap_hit = (q_reg == '1);
`ifdef REGISTER_BANK_SAT_EN
          q_next = wrap_hit ? q_reg : q_reg + ONE;
`else
          q_next = q_reg + ONE;
`endif
        end
        FS_LOAD: q_next = din;
        FS_CLR:  q_next = '0;
        FS_LDZX: q_next = {{(WIDTH-BYTE_W){1'b0}}, din[BYTE_W-1:0]};
        FS_LDLO: q_next[BYTE_W-1:0] = din[BYTE_W-1:0];
        // High-byte lane is always bits 15:8, even for wider registers.
        FS_LDHI: q_next[2*BYTE_W-1:BYTE_W] = din[BYTE_W-1:0];
        FS_SHL8: q_next = {q_reg[WIDTH-BYTE_W-1:0], din[BYTE_W-1:0]};
        default: q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_reg <= '0;
    else        q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/register_bank.sv
// Bank of NUM_REGS WIDTH-bit registers with two combinational read ports and a registered Wrap flag.
// Define REGISTER_BANK_SAT_EN for saturating increment/decrement.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic [WIDTH-1:0]            I,
  input  logic [2:0]                  FunSel,
  input  logic [NUM_REGS-1:0]         RegSel,
  input  logic [$clog2(NUM_REGS)-1:0] OutASel,
  input  logic [$clog2(NUM_REGS)-1:0] OutBSel,
  output logic [WIDTH-1:0]            OutA,
  output logic [WIDTH-1:0]            OutB,
  output logic                        Wrap
);

  localparam int SEL_W = $clog2(NUM_REGS);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("register_bank: WIDTH must be a multiple of 8 and at least 16");
  end
  if (NUM_REGS < 2 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("register_bank: NUM_REGS must be in 2..16");
  end

  logic [WIDTH-1:0]    q [NUM_REGS];
  logic [NUM_REGS-1:0] hit;
  logic                wrap_reg;
  funsel_e             fun_sel;

  assign fun_sel = funsel_e'(FunSel);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
    register_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk     (Clock),
      .rst_n   (Reset_n),
      .en      (RegSel[gi]),
      .fun_sel (fun_sel),
      .din     (I),
      .q       (q[gi]),
      .wrap_hit(hit[gi])
    );
  end

  // Indices with no matching register fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (OutASel == SEL_W'(k)) OutA = q[k];
      if (OutBSel == SEL_W'(k)) OutB = q[k];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) wrap_reg <= 1'b0;
    else          wrap_reg <= |hit;
  end

  assign Wrap = wrap_reg;

endmodule
